// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: per-channel start/stop/halt control of active-low
// clock-gate enables with cycle budget, drain delay and cycle counters.
module clock_gate_ctrl #(
  parameter int CHANNELS     = 4,
  parameter int COUNT_WIDTH  = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            start_valid,
  input  logic [CHANNELS-1:0]             start_mask,
  input  logic [COUNT_WIDTH-1:0]          start_budget,
  input  logic                            stop_valid,
  input  logic [CHANNELS-1:0]             stop_mask,
  input  logic [CHANNELS-1:0]             halt_req,
  output logic [CHANNELS-1:0]             ce_n,
  output logic [CHANNELS-1:0]             running,
  output logic [CHANNELS-1:0]             done,
  output logic [CHANNELS-1:0]             halted,
  output logic                            cmd_err,
  output logic [CHANNELS*COUNT_WIDTH-1:0] cycles
);

  localparam int DW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD =
    DW'(DRAIN_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] ONE =
    COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_RUNNING,
    ST_DRAINING
  } state_e;

  state_e                 state_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] rem_q   [CHANNELS];
  logic [COUNT_WIDTH-1:0] cyc_q   [CHANNELS];
  logic [DW-1:0]          drn_q   [CHANNELS];
  logic [CHANNELS-1:0]    ce_n_q;
  logic [CHANNELS-1:0]    done_q;
  logic [CHANNELS-1:0]    halted_q;
  logic                   cmd_err_q;

  logic [CHANNELS-1:0]    start_hit;
  logic [CHANNELS-1:0]    stop_hit;
  logic [CHANNELS-1:0]    busy;
  logic                   cmd_err_d;

  // Decode command hits; a start to a busy channel is an error
  always_comb begin
    start_hit = start_valid ? start_mask : '0;
    stop_hit  = stop_valid ? stop_mask : '0;
    busy      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      busy[i] = (state_q[i] != ST_STOPPED);
    end
    cmd_err_d = |(start_hit & busy);
  end

  // Per-channel FSM: halt > stop > budget expiry > start
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cmd_err_q <= 1'b0;
      ce_n_q    <= '1;
      done_q    <= '0;
      halted_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_STOPPED;
        rem_q[i]   <= '0;
        cyc_q[i]   <= '0;
        drn_q[i]   <= '0;
      end
    end else begin
      cmd_err_q <= cmd_err_d;
      for (int i = 0; i < CHANNELS; i++) begin
        done_q[i] <= 1'b0;
        if (!ce_n_q[i]) begin
          cyc_q[i] <= cyc_q[i] + ONE;
        end
        unique case (state_q[i])
          ST_STOPPED: begin
            if (start_hit[i] && !halt_req[i]) begin
              state_q[i]  <= ST_RUNNING;
              rem_q[i]    <= start_budget;
              cyc_q[i]    <= '0;
              halted_q[i] <= 1'b0;
              ce_n_q[i]   <= 1'b0;
            end
          end
          ST_RUNNING: begin
            if (halt_req[i]) begin
              state_q[i]  <= ST_DRAINING;
              drn_q[i]    <= DRAIN_LOAD;
              ce_n_q[i]   <= 1'b1;
              halted_q[i] <= 1'b1;
            end else if (stop_hit[i] ||
                         rem_q[i] == ONE) begin
              state_q[i] <= ST_DRAINING;
              drn_q[i]   <= DRAIN_LOAD;
              ce_n_q[i]  <= 1'b1;
            end else if (rem_q[i] != '0) begin
              rem_q[i] <= rem_q[i] - ONE;
            end
          end
          ST_DRAINING: begin
            if (drn_q[i] == '0) begin
              state_q[i] <= ST_STOPPED;
              done_q[i]  <= 1'b1;
            end else begin
              drn_q[i] <= drn_q[i] - 1'b1;
            end
          end
          default: begin
            state_q[i] <= ST_STOPPED;
            ce_n_q[i]  <= 1'b1;
          end
        endcase
      end
    end
  end

  // Flatten per-channel counters onto the output bus
  always_comb begin
    cycles = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cycles[i*COUNT_WIDTH +: COUNT_WIDTH] = cyc_q[i];
    end
  end

  assign ce_n    = ce_n_q;
  assign running = ~ce_n_q;
  assign done    = done_q;
  assign halted  = halted_q;
  assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb_clock_gate_ctrl: directed scenarios plus randomized traffic
// checked against a timestamp-based reference model.
module tb_clock_gate_ctrl;

  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 2;
  localparam longint INF = 64'sh3fff_ffff_ffff_ffff;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           start_valid = 1'b0;
  logic [N-1:0]   start_mask = '0;
  logic [W-1:0]   start_budget = '0;
  logic           stop_valid = 1'b0;
  logic [N-1:0]   stop_mask = '0;
  logic [N-1:0]   halt_req = '0;
  logic [N-1:0]   ce_n;
  logic [N-1:0]   running;
  logic [N-1:0]   done;
  logic [N-1:0]   halted;
  logic           cmd_err;
  logic [N*W-1:0] cycles;

  logic           s_start_valid = 1'b0;
  logic [N-1:0]   s_start_mask = '0;
  logic [3:0]     s_budget = '0;
  logic           s_stop_valid = 1'b0;
  logic [N-1:0]   s_stop_mask = '0;
  logic [N-1:0]   s_halt = '0;
  logic [N-1:0]   s_ce_n;
  logic [N-1:0]   s_running;
  logic [N-1:0]   s_done;
  logic [N-1:0]   s_halted;
  logic           s_cmd_err;
  logic [N*4-1:0] s_cycles;

  always #5 clock = ~clock;

  clock_gate_ctrl #(
    .CHANNELS(N), .COUNT_WIDTH(W), .DRAIN_CYCLES(D)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .start_valid(start_valid), .start_mask(start_mask),
    .start_budget(start_budget),
    .stop_valid(stop_valid), .stop_mask(stop_mask),
    .halt_req(halt_req),
    .ce_n(ce_n), .running(running), .done(done),
    .halted(halted), .cmd_err(cmd_err), .cycles(cycles)
  );

  clock_gate_ctrl #(
    .CHANNELS(N), .COUNT_WIDTH(4), .DRAIN_CYCLES(D)
  ) dut_small (
    .clock(clock), .reset_n(reset_n),
    .start_valid(s_start_valid), .start_mask(s_start_mask),
    .start_budget(s_budget),
    .stop_valid(s_stop_valid), .stop_mask(s_stop_mask),
    .halt_req(s_halt),
    .ce_n(s_ce_n), .running(s_running), .done(s_done),
    .halted(s_halted), .cmd_err(s_cmd_err), .cycles(s_cycles)
  );

  int n_pass = 0;
  int n_total = 0;
  longint edge_n = 0;

  // Model: each channel is described by the edge its run started
  // and the edge its enable rose; everything else is arithmetic.
  longint m_start [N];
  longint m_end   [N];
  bit     m_act   [N];
  bit     m_halted[N];
  bit     m_err;

  function automatic void model_edge(longint n);
    bit run;
    bit busy;
    m_err = 1'b0;
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_act[i] = 1'b0;
        m_halted[i] = 1'b0;
      end
      return;
    end
    for (int i = 0; i < N; i++) begin
      run  = m_act[i] && m_start[i] < n && n <= m_end[i];
      busy = m_act[i] && n <= m_end[i] + D;
      if (run) begin
        if (halt_req[i]) begin
          m_end[i] = n;
          m_halted[i] = 1'b1;
        end else if (stop_valid && stop_mask[i]) begin
          m_end[i] = n;
        end
      end
      if (start_valid && start_mask[i]) begin
        if (busy) begin
          m_err = 1'b1;
        end else if (!halt_req[i]) begin
          m_act[i] = 1'b1;
          m_start[i] = n;
          m_end[i] = (start_budget == 0) ? INF :
                     n + longint'(start_budget);
          m_halted[i] = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_ce_n();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[i] = !(m_act[i] && m_start[i] <= edge_n &&
               edge_n < m_end[i]);
    end
    return v;
  endfunction

  function automatic logic [N-1:0] exp_done();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[i] = m_act[i] && edge_n == m_end[i] + D;
    end
    return v;
  endfunction

  function automatic logic [N-1:0] exp_halted();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_halted[i];
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_cycles();
    logic [N*W-1:0] v;
    longint c;
    v = '0;
    for (int i = 0; i < N; i++) begin
      c = 0;
      if (m_act[i]) begin
        c = ((edge_n < m_end[i]) ? edge_n : m_end[i]) - m_start[i];
      end
      v[i*W +: W] = c[W-1:0];
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    edge_n++;
    model_edge(edge_n);
    #1;
  endtask

  task automatic idle();
    start_valid = 1'b0;
    start_mask = '0;
    start_budget = '0;
    stop_valid = 1'b0;
    stop_mask = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    step();
    step();
    n_total++;
    if (ce_n !== 4'b1111) $display("FAIL reset_ce_n got %b want 1111", ce_n);
    else n_pass++;
    n_total++;
    if (running !== 4'b0000) $display("FAIL reset_running got %b want 0000", running);
    else n_pass++;
    n_total++;
    if ({done, halted, cmd_err} !== 9'b0)
      $display("FAIL reset_flags got %b want 0", {done, halted, cmd_err});
    else n_pass++;
    n_total++;
    if (cycles !== '0) $display("FAIL reset_cycles got %h want 0", cycles);
    else n_pass++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_budget3();
    logic [N-1:0] want_ce;
    start_valid = 1'b1;
    start_mask = 4'b0001;
    start_budget = 3;
    step();
    idle();
    for (int off = 0; off < 7; off++) begin
      if (off > 0) step();
      want_ce = 4'b1111;
      if (off < 3) want_ce[0] = 1'b0;
      n_total++;
      if (ce_n !== want_ce)
        $display("FAIL budget3_ce off=%0d got %b want %b", off, ce_n, want_ce);
      else n_pass++;
      n_total++;
      if (done[0] !== (off == 5))
        $display("FAIL budget3_done off=%0d got %b want %b", off, done[0], off == 5);
      else n_pass++;
    end
    n_total++;
    if (cycles[W-1:0] !== 32'd3)
      $display("FAIL budget3_cycles got %0d want 3", cycles[W-1:0]);
    else n_pass++;
    n_total++;
    if (cycles !== exp_cycles())
      $display("FAIL budget3_allcyc got %h want %h", cycles, exp_cycles());
    else n_pass++;
  endtask

  task automatic test_freerun_stop();
    start_valid = 1'b1;
    start_mask = 4'b0110;
    start_budget = 0;
    step();
    idle();
    repeat (99) step();
    stop_valid = 1'b1;
    stop_mask = 4'b0010;
    step();
    idle();
    n_total++;
    if (cycles[W +: W] !== 32'd100)
      $display("FAIL free_ch1_cycles got %0d want 100", cycles[W +: W]);
    else n_pass++;
    n_total++;
    if (ce_n[2:1] !== 2'b01)
      $display("FAIL free_ce got %b want 01", ce_n[2:1]);
    else n_pass++;
    step();
    step();
    n_total++;
    if (done[2:1] !== 2'b01)
      $display("FAIL free_done got %b want 01", done[2:1]);
    else n_pass++;
    n_total++;
    if (cycles[2*W +: W] !== 32'd102)
      $display("FAIL free_ch2_cycles got %0d want 102", cycles[2*W +: W]);
    else n_pass++;
    stop_valid = 1'b1;
    stop_mask = 4'b0100;
    step();
    idle();
    repeat (3) step();
    n_total++;
    if (ce_n !== exp_ce_n())
      $display("FAIL free_end_ce got %b want %b", ce_n, exp_ce_n());
    else n_pass++;
  endtask

  task automatic test_halt();
    start_valid = 1'b1;
    start_mask = 4'b1000;
    start_budget = 50;
    step();
    idle();
    repeat (19) step();
    halt_req[3] = 1'b1;
    step();
    n_total++;
    if (ce_n[3] !== 1'b1) $display("FAIL halt_ce got %b want 1", ce_n[3]);
    else n_pass++;
    n_total++;
    if (cycles[3*W +: W] !== 32'd20)
      $display("FAIL halt_cycles got %0d want 20", cycles[3*W +: W]);
    else n_pass++;
    n_total++;
    if (halted[3] !== 1'b1) $display("FAIL halt_flag got %b want 1", halted[3]);
    else n_pass++;
    step();
    step();
    n_total++;
    if (done[3] !== 1'b1) $display("FAIL halt_done got %b want 1", done[3]);
    else n_pass++;
    start_valid = 1'b1;
    start_mask = 4'b1000;
    start_budget = 5;
    step();
    idle();
    n_total++;
    if ({ce_n[3], cmd_err, done[3], halted[3]} !== 4'b1001)
      $display("FAIL halt_drop got %b want 1001", {ce_n[3], cmd_err, done[3], halted[3]});
    else n_pass++;
    halt_req[3] = 1'b0;
    step();
    start_valid = 1'b1;
    start_mask = 4'b1000;
    start_budget = 4;
    step();
    idle();
    n_total++;
    if ({ce_n[3], halted[3]} !== 2'b00)
      $display("FAIL halt_restart got %b want 00", {ce_n[3], halted[3]});
    else n_pass++;
    repeat (4 + D + 1) step();
    n_total++;
    if ({ce_n, halted} !== {exp_ce_n(), exp_halted()})
      $display("FAIL halt_end got %b want %b", {ce_n, halted}, {exp_ce_n(), exp_halted()});
    else n_pass++;
  endtask

  task automatic test_collide();
    start_valid = 1'b1;
    start_mask = 4'b0001;
    start_budget = 0;
    step();
    idle();
    repeat (3) step();
    start_valid = 1'b1;
    start_mask = 4'b0001;
    stop_valid = 1'b1;
    stop_mask = 4'b0001;
    step();
    idle();
    n_total++;
    if ({cmd_err, ce_n[0]} !== 2'b11)
      $display("FAIL collide_stop got %b want 11", {cmd_err, ce_n[0]});
    else n_pass++;
    n_total++;
    if (cycles[W-1:0] !== 32'd4)
      $display("FAIL collide_cycles got %0d want 4", cycles[W-1:0]);
    else n_pass++;
    start_valid = 1'b1;
    start_mask = 4'b0001;
    step();
    idle();
    n_total++;
    if ({cmd_err, done[0]} !== 2'b10)
      $display("FAIL drain_start got %b want 10", {cmd_err, done[0]});
    else n_pass++;
    step();
    n_total++;
    if ({cmd_err, done[0], ce_n[0]} !== 3'b011)
      $display("FAIL drain_done got %b want 011", {cmd_err, done[0], ce_n[0]});
    else n_pass++;
    step();
  endtask

  task automatic test_budget1();
    int lows;
    int done_off;
    lows = 0;
    done_off = -1;
    start_valid = 1'b1;
    start_mask = 4'b0100;
    start_budget = 1;
    step();
    idle();
    for (int off = 0; off < 6; off++) begin
      if (off > 0) step();
      if (!ce_n[2]) lows++;
      if (done[2]) done_off = off;
    end
    n_total++;
    if (lows != 1) $display("FAIL budget1_lows got %0d want 1", lows);
    else n_pass++;
    n_total++;
    if (done_off != 1 + D)
      $display("FAIL budget1_done_at got %0d want %0d", done_off, 1 + D);
    else n_pass++;
    n_total++;
    if (cycles[2*W +: W] !== 32'd1)
      $display("FAIL budget1_cycles got %0d want 1", cycles[2*W +: W]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    s_start_valid = 1'b1;
    s_start_mask = 4'b0001;
    s_budget = 4'd0;
    step();
    s_start_valid = 1'b0;
    s_start_mask = '0;
    repeat (16) step();
    n_total++;
    if (s_cycles[3:0] !== 4'd0)
      $display("FAIL wrap16 got %0d want 0", s_cycles[3:0]);
    else n_pass++;
    step();
    n_total++;
    if (s_cycles[3:0] !== 4'd1)
      $display("FAIL wrap17 got %0d want 1", s_cycles[3:0]);
    else n_pass++;
    s_stop_valid = 1'b1;
    s_stop_mask = 4'b0001;
    step();
    s_stop_valid = 1'b0;
    s_stop_mask = '0;
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    start_valid = 1'b1;
    start_mask = 4'b0001;
    start_budget = 0;
    step();
    start_mask = 4'b0010;
    start_budget = 1;
    step();
    idle();
    step();
    n_total++;
    if (ce_n[1:0] !== 2'b10)
      $display("FAIL rmid_pre got %b want 10", ce_n[1:0]);
    else n_pass++;
    reset_n = 1'b0;
    step();
    n_total++;
    if ({ce_n, done, cycles} !== {4'b1111, 4'b0000, 128'b0})
      $display("FAIL rmid_state ce_n %b done %b cycles %h", ce_n, done, cycles);
    else n_pass++;
    step();
    n_total++;
    if (done !== 4'b0000) $display("FAIL rmid_nodone got %b want 0000", done);
    else n_pass++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      start_valid = ($urandom_range(0, 3) == 0);
      start_mask = 4'($urandom_range(0, 15));
      start_budget = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 12);
      stop_valid = ($urandom_range(0, 7) == 0);
      stop_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) begin
        int h;
        h = $urandom_range(0, N - 1);
        halt_req[h] = ~halt_req[h];
      end
      step();
      n_total++;
      if ({ce_n, running, done} !== {exp_ce_n(), ~exp_ce_n(), exp_done()})
        $display("FAIL rand_ctl c=%0d got %b want %b", c,
                 {ce_n, running, done}, {exp_ce_n(), ~exp_ce_n(), exp_done()});
      else n_pass++;
      n_total++;
      if ({halted, cmd_err} !== {exp_halted(), m_err})
        $display("FAIL rand_flags c=%0d got %b want %b", c,
                 {halted, cmd_err}, {exp_halted(), m_err});
      else n_pass++;
      n_total++;
      if (cycles !== exp_cycles())
        $display("FAIL rand_cycles c=%0d got %h want %h", c, cycles, exp_cycles());
      else n_pass++;
    end
    idle();
    halt_req = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_act[i] = 1'b0;
      m_halted[i] = 1'b0;
      m_start[i] = 0;
      m_end[i] = 0;
    end
    m_err = 1'b0;
    test_reset();
    test_budget3();
    test_freerun_stop();
    test_halt();
    test_collide();
    test_budget1();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
